// File: rtl/fir_host_seq.sv
// fir_host_seq: processor-side job sequencer for the FIR peripheral bus.
// Streams coefficients into the coefficient RAM, programs the length registers,
// kicks START and polls DONE with a bounded poll count.
module fir_host_seq #(
    parameter int WR_HOLD  = 2,
    parameter int READ_LAT = 4,
    parameter int POLL_MAX = 1000
) (
    input  logic        clk_a,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [5:0]  cmd_n_coef,
    input  logic [13:0] cmd_n_samples,
    input  logic        coef_valid,
    output logic        coef_ready,
    input  logic [15:0] coef_data,
    output logic [5:0]  p_address,
    output logic [15:0] p_data,
    output logic        p_wr,
    input  logic [15:0] p_data_back,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] last_status
);
    typedef enum logic [2:0] {
        IDLE, LOAD, WR_COEF, WR_NWSP, WR_NPROB, WR_START, POLL
    } state_t;

    localparam int CMAX = (WR_HOLD > READ_LAT) ? WR_HOLD : READ_LAT;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int PW   = $clog2(POLL_MAX + 1);
    localparam logic [CW-1:0] HOLD_END  = CW'(WR_HOLD);
    localparam logic [CW-1:0] HOLD_LAST = CW'(WR_HOLD - 1);
    localparam logic [CW-1:0] READ_END  = CW'(READ_LAT);
    localparam logic [PW-1:0] POLL_LAST = PW'(POLL_MAX - 1);

    state_t         state, state_nx;
    logic [CW-1:0]  cnt;
    logic [5:0]     idx;
    logic [5:0]     n_coef;
    logic [13:0]    n_samples;
    logic [PW-1:0]  polls;

    logic           is_wr, cur_beat, nx_beat, beat_end, beat_start;
    logic           accept, cmd_ok, poll_hit, poll_last;
    logic [5:0]     beat_addr;
    logic [15:0]    beat_data;
    logic           beat_wr;

    assign is_wr      = state inside {WR_COEF, WR_NWSP, WR_NPROB, WR_START};
    assign cur_beat   = is_wr || (state == POLL);
    assign nx_beat    = state_nx inside {WR_COEF, WR_NWSP, WR_NPROB, WR_START, POLL};
    assign beat_end   = is_wr ? (cnt == HOLD_END) : ((state == POLL) && (cnt == READ_END));
    // a new beat begins on entry to a beat state or when one beat rolls straight into the next
    assign beat_start = nx_beat && (!cur_beat || beat_end);
    assign accept     = cmd_valid && (state == IDLE);
    assign cmd_ok     = (cmd_n_coef != 6'd0) && (cmd_n_coef <= 6'd32);
    assign poll_hit   = p_data_back[0];
    assign poll_last  = (polls == POLL_LAST);

    // state register
    always_ff @(posedge clk_a or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (accept && cmd_ok) state_nx = LOAD;
            LOAD:     if (coef_valid) state_nx = WR_COEF;
            WR_COEF:  if (beat_end) state_nx = (idx + 6'd1 == n_coef) ? WR_NWSP : LOAD;
            WR_NWSP:  if (beat_end) state_nx = WR_NPROB;
            WR_NPROB: if (beat_end) state_nx = WR_START;
            WR_START: if (beat_end) state_nx = POLL;
            POLL:     if (beat_end && (poll_hit || poll_last)) state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    // handshake/status outputs; cmd_ready is held low while reset is applied
    always_comb begin
        cmd_ready  = (state == IDLE) && !rst;
        coef_ready = (state == LOAD);
        busy       = (state != IDLE);
    end

    // contents of the beat about to start, keyed on the state being entered
    always_comb begin
        beat_addr = p_address;
        beat_data = p_data;
        beat_wr   = 1'b0;
        case (state_nx)
            WR_COEF:  begin beat_addr = {1'b0, idx[4:0]}; beat_data = coef_data;             beat_wr = 1'b1; end
            WR_NWSP:  begin beat_addr = 6'h23;            beat_data = {10'b0, n_coef};       beat_wr = 1'b1; end
            WR_NPROB: begin beat_addr = 6'h24;            beat_data = {2'b0, n_samples};     beat_wr = 1'b1; end
            WR_START: begin beat_addr = 6'h20;            beat_data = 16'd1;                 beat_wr = 1'b1; end
            POLL:     begin beat_addr = 6'h22;            beat_data = 16'd0;                 beat_wr = 1'b0; end
            default:  ;
        endcase
    end

    // datapath: job latches, beat counter, bus drive, poll bookkeeping and result pulses
    always_ff @(posedge clk_a or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            idx         <= '0;
            n_coef      <= '0;
            n_samples   <= '0;
            polls       <= '0;
            p_address   <= '0;
            p_data      <= '0;
            p_wr        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            last_status <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (accept) begin
                n_coef    <= cmd_n_coef;
                n_samples <= cmd_n_samples;
                idx       <= '0;
                err       <= !cmd_ok;
            end
            if (beat_start) begin
                cnt       <= '0;
                p_address <= beat_addr;
                p_data    <= beat_data;
                p_wr      <= beat_wr;
            end else if (cur_beat) begin
                cnt <= cnt + 1'b1;
                // strobe drops after WR_HOLD cycles, leaving the final cycle as the gap
                if (is_wr && cnt == HOLD_LAST) p_wr <= 1'b0;
            end
            if (state == WR_COEF && beat_end) idx <= idx + 6'd1;
            if (state == WR_START && beat_end) polls <= '0;
            if (state == POLL && beat_end) begin
                polls       <= polls + 1'b1;
                last_status <= p_data_back;
                if (poll_hit)       done <= 1'b1;
                else if (poll_last) err  <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fir_host_seq.sv
// Bench for fir_host_seq: table of jobs plus a mid-job reset sequence.
// Expected bus writes are queued as stimulus is driven and checked by a bus monitor.
module tb_fir_host_seq;
    localparam int WR_HOLD  = 2;
    localparam int READ_LAT = 4;
    localparam int POLL_MAX = 5;

    logic        clk_a = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [5:0]  cmd_n_coef = '0;
    logic [13:0] cmd_n_samples = '0;
    logic        coef_valid = 1'b0;
    logic        coef_ready;
    logic [15:0] coef_data = '0;
    logic [5:0]  p_address;
    logic [15:0] p_data;
    logic        p_wr;
    logic [15:0] p_data_back;
    logic        busy, done, err;
    logic [15:0] last_status;

    fir_host_seq #(.WR_HOLD(WR_HOLD), .READ_LAT(READ_LAT), .POLL_MAX(POLL_MAX)) dut (
        .clk_a(clk_a), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_n_coef(cmd_n_coef), .cmd_n_samples(cmd_n_samples),
        .coef_valid(coef_valid), .coef_ready(coef_ready), .coef_data(coef_data),
        .p_address(p_address), .p_data(p_data), .p_wr(p_wr), .p_data_back(p_data_back),
        .busy(busy), .done(done), .err(err), .last_status(last_status)
    );

    always #5 clk_a = ~clk_a;

    typedef struct packed { logic [5:0] a; logic [15:0] d; } wr_t;
    typedef struct {
        int n; int ns; int da; bit legal;
        bit ex_done; bit ex_err; int ex_reads; int ex_status;
    } vec_t;

    wr_t sb_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    int  done_after = 0;   // DONE reads back as set once this many poll cycles have elapsed (0 = never)
    int  pcyc = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // peripheral model: cycles spent with the DONE address presented as a read
    always @(posedge clk_a) pcyc <= (p_address == 6'h22 && !p_wr) ? pcyc + 1 : 0;
    always_comb p_data_back = (done_after != 0 && pcyc >= done_after) ? 16'h8001 : 16'h0000;

    // bus monitor: pops expected writes, checks hold length and stability
    logic       in_beat = 1'b0;
    int         hi = 0;
    logic [5:0] cur_a;
    logic [15:0] cur_d;
    always @(negedge clk_a) begin
        if (rst) begin
            in_beat = 1'b0;
        end else if (p_wr && !in_beat) begin
            in_beat = 1'b1; hi = 1; cur_a = p_address; cur_d = p_data;
            if (sb_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_wr: got addr 0x%0h data 0x%0h expected no write", p_address, p_data);
            end else begin
                wr_t e;
                e = sb_q.pop_front();
                check("wr_addr", p_address, e.a);
                check("wr_data", p_data, e.d);
            end
        end else if (p_wr && in_beat) begin
            hi++;
            check("wr_stable", {p_address, p_data}, {cur_a, cur_d});
        end else if (!p_wr && in_beat) begin
            in_beat = 1'b0;
            check("wr_hold", hi, WR_HOLD);
        end
    end

    task automatic send_cmd(input int n, input int ns);
        bit ok = 0;
        cmd_valid = 1'b1; cmd_n_coef = 6'(n); cmd_n_samples = 14'(ns);
        for (int k = 0; k < 50; k++) begin
            if (cmd_ready) begin ok = 1; break; end
            @(negedge clk_a);
        end
        if (!ok) begin n_cmp++; n_bad++; $display("FAIL cmd_timeout: got no cmd_ready expected accept"); end
        @(negedge clk_a);
        cmd_valid = 1'b0;
    endtask

    task automatic send_coef(input logic [15:0] d);
        bit ok = 0;
        coef_valid = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk_a);
        coef_valid = 1'b1; coef_data = d;
        for (int k = 0; k < 50; k++) begin
            if (coef_ready) begin ok = 1; break; end
            @(negedge clk_a);
        end
        if (!ok) begin n_cmp++; n_bad++; $display("FAIL coef_timeout: got no coef_ready expected accept"); end
        @(negedge clk_a);
        coef_valid = 1'b0;
    endtask

    task automatic run_job(input vec_t v);
        logic [5:0] prev;
        int n0 = -1;
        int k;
        done_after = v.da;
        send_cmd(v.n, v.ns);
        if (v.legal) begin
            for (int i = 0; i < v.n; i++) begin
                logic [15:0] c;
                c = (v.n <= 3) ? 16'(16'h0011 * (i + 1)) : 16'($urandom_range(0, 65535));
                sb_q.push_back({6'(i), c});
                send_coef(c);
            end
            sb_q.push_back({6'h23, 16'(v.n)});
            sb_q.push_back({6'h24, 16'(v.ns)});
            sb_q.push_back({6'h20, 16'd1});
        end
        prev = p_address;
        for (k = 0; k < 4000; k++) begin
            if (k > 0 && n0 < 0 && prev == 6'h20 && p_address == 6'h22) n0 = k;
            prev = p_address;
            if (done || err) break;
            @(negedge clk_a);
        end
        if (k == 4000) begin n_cmp++; n_bad++; $display("FAIL job_timeout: got no done/err expected one"); end
        check("done", done, v.ex_done);
        check("err", err, v.ex_err);
        if (v.ex_reads >= 0) check("reads", (n0 < 0) ? -1 : (k - n0) / (READ_LAT + 1), v.ex_reads);
        if (v.ex_status >= 0) check("last_status", last_status, v.ex_status);
        check("busy_end", busy, 0);
        check("cmd_ready_end", cmd_ready, 1);
        check("sb_empty", sb_q.size(), 0);
        @(negedge clk_a);
        check("pulse_len", {done, err}, 2'b00);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got time limit expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[5];
        vecs[0] = '{n:3,  ns:10,    da:5, legal:1, ex_done:1, ex_err:0, ex_reads:2,  ex_status:'h8001};
        vecs[1] = '{n:0,  ns:7,     da:0, legal:0, ex_done:0, ex_err:1, ex_reads:-1, ex_status:-1};
        vecs[2] = '{n:33, ns:7,     da:0, legal:0, ex_done:0, ex_err:1, ex_reads:-1, ex_status:-1};
        vecs[3] = '{n:32, ns:16383, da:1, legal:1, ex_done:1, ex_err:0, ex_reads:1,  ex_status:'h8001};
        vecs[4] = '{n:1,  ns:0,     da:0, legal:1, ex_done:0, ex_err:1, ex_reads:5,  ex_status:0};

        // reset state
        repeat (2) @(negedge clk_a);
        check("rst_p_wr", p_wr, 0);
        check("rst_p_address", p_address, 0);
        check("rst_p_data", p_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done_err", {done, err}, 0);
        check("rst_last_status", last_status, 0);
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_coef_ready", coef_ready, 0);
        rst = 1'b0;
        @(negedge clk_a);
        check("idle_cmd_ready", cmd_ready, 1);

        for (int i = 0; i < 5; i++) run_job(vecs[i]);

        // reset while the third coefficient write is on the bus
        done_after = 5;
        send_cmd(4, 9);
        for (int i = 0; i < 3; i++) begin
            sb_q.push_back({6'(i), 16'(16'h0100 + i)});
            send_coef(16'(16'h0100 + i));
        end
        check("pre_rst_p_wr", p_wr, 1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_p_wr", p_wr, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_sb", sb_q.size(), 0);
        repeat (2) @(negedge clk_a);
        rst = 1'b0;
        @(negedge clk_a);
        check("post_rst_cmd_ready", cmd_ready, 1);
        run_job('{n:2, ns:5, da:5, legal:1, ex_done:1, ex_err:0, ex_reads:2, ex_status:'h8001});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
